// File: rtl/pkt_meta_joiner_if.sv
// Joiner bus: upstream packet and metadata streams in, joined packet+metadata stream out.
interface pkt_meta_joiner_if #(
    parameter int DATA_W  = 512,
    parameter int EMPTY_W = 6,
    parameter int META_W  = 128
);
    logic               in_pkt_valid;
    logic               in_pkt_sop;
    logic               in_pkt_eop;
    logic [DATA_W-1:0]  in_pkt_data;
    logic [EMPTY_W-1:0] in_pkt_empty;
    logic               in_pkt_ready;
    logic               in_meta_valid;
    logic [META_W-1:0]  in_meta_data;
    logic               in_meta_ready;
    logic               out_valid;
    logic               out_sop;
    logic               out_eop;
    logic [DATA_W-1:0]  out_data;
    logic [EMPTY_W-1:0] out_empty;
    logic [META_W-1:0]  out_meta;
    logic               out_ready;

    modport slave (
        input  in_pkt_valid, in_pkt_sop, in_pkt_eop, in_pkt_data, in_pkt_empty,
        output in_pkt_ready,
        input  in_meta_valid, in_meta_data,
        output in_meta_ready,
        output out_valid, out_sop, out_eop, out_data, out_empty, out_meta,
        input  out_ready
    );

    modport master (
        output in_pkt_valid, in_pkt_sop, in_pkt_eop, in_pkt_data, in_pkt_empty,
        input  in_pkt_ready,
        output in_meta_valid, in_meta_data,
        input  in_meta_ready,
        input  out_valid, out_sop, out_eop, out_data, out_empty, out_meta,
        output out_ready
    );
endinterface

// File: rtl/pkt_meta_joiner.sv
// Attaches one metadata word to each packet and holds it on every flit; drops
// leading non-sop flits and counts completed packets, drops and stray sops.
module pkt_meta_joiner #(
    parameter int DATA_W  = 512,
    parameter int EMPTY_W = 6,
    parameter int META_W  = 128
) (
    input  logic               Clk,
    input  logic               Rst,
    pkt_meta_joiner_if.slave   bus,
    output logic [31:0]        stats_pkt,
    output logic [31:0]        stats_drop,
    output logic [31:0]        stats_err
);
    typedef enum logic {IDLE, BODY} state_t;

    state_t            state, state_nxt;
    logic              adv;
    logic              load;
    logic              load_sop;
    logic              drop_inc;
    logic              err_inc;
    logic [META_W-1:0] meta_r;
    logic [META_W-1:0] load_meta;

    assign adv = !bus.out_valid || bus.out_ready;

    always_comb begin
        state_nxt         = state;
        bus.in_pkt_ready  = 1'b0;
        bus.in_meta_ready = 1'b0;
        load              = 1'b0;
        load_sop          = 1'b0;
        load_meta         = meta_r;
        drop_inc          = 1'b0;
        err_inc           = 1'b0;
        if (!Rst) begin
            case (state)
                IDLE: begin
                    if (bus.in_pkt_valid && !bus.in_pkt_sop) begin
                        bus.in_pkt_ready = 1'b1;
                        drop_inc         = 1'b1;
                    end else if (bus.in_pkt_valid && bus.in_meta_valid && adv) begin
                        // sop and its metadata are popped together or not at all
                        bus.in_pkt_ready  = 1'b1;
                        bus.in_meta_ready = 1'b1;
                        load              = 1'b1;
                        load_sop          = 1'b1;
                        load_meta         = bus.in_meta_data;
                        if (!bus.in_pkt_eop) state_nxt = BODY;
                    end
                end
                BODY: begin
                    bus.in_pkt_ready = adv;
                    if (bus.in_pkt_valid && adv) begin
                        load    = 1'b1;
                        err_inc = bus.in_pkt_sop;
                        if (bus.in_pkt_eop) state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state         <= IDLE;
            meta_r        <= '0;
            bus.out_valid <= 1'b0;
            bus.out_sop   <= 1'b0;
            bus.out_eop   <= 1'b0;
            bus.out_data  <= '0;
            bus.out_empty <= '0;
            bus.out_meta  <= '0;
            stats_pkt     <= '0;
            stats_drop    <= '0;
            stats_err     <= '0;
        end else begin
            state <= state_nxt;
            if (bus.in_meta_ready) meta_r <= bus.in_meta_data;
            if (load) begin
                bus.out_valid <= 1'b1;
                bus.out_sop   <= load_sop;
                bus.out_eop   <= bus.in_pkt_eop;
                bus.out_data  <= bus.in_pkt_data;
                bus.out_empty <= bus.in_pkt_empty;
                bus.out_meta  <= load_meta;
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
            if (bus.out_valid && bus.out_ready && bus.out_eop) stats_pkt <= stats_pkt + 32'd1;
            if (drop_inc) stats_drop <= stats_drop + 32'd1;
            if (err_inc)  stats_err  <= stats_err + 32'd1;
        end
    end
endmodule

// File: tb/tb_pkt_meta_joiner.sv
// Randomized and directed stimulus for pkt_meta_joiner, checked against a
// packet-level reference model of the join/drop/stray-sop rules.
module tb_pkt_meta_joiner;
    localparam int DW = 64;
    localparam int EW = 3;
    localparam int MW = 32;

    typedef struct {
        logic          sop;
        logic          eop;
        logic [DW-1:0] data;
        logic [EW-1:0] empty;
    } flit_t;

    typedef struct {
        logic          sop;
        logic          eop;
        logic [DW-1:0] data;
        logic [EW-1:0] empty;
        logic [MW-1:0] meta;
    } oflit_t;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [31:0] stats_pkt, stats_drop, stats_err;

    always #5 Clk = ~Clk;

    pkt_meta_joiner_if #(.DATA_W(DW), .EMPTY_W(EW), .META_W(MW)) bus ();

    pkt_meta_joiner #(.DATA_W(DW), .EMPTY_W(EW), .META_W(MW)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .bus        (bus),
        .stats_pkt  (stats_pkt),
        .stats_drop (stats_drop),
        .stats_err  (stats_err)
    );

    int unsigned   checks = 0;
    int unsigned   passed = 0;
    flit_t         src_q[$];
    logic [MW-1:0] meta_q[$];
    logic [MW-1:0] model_meta_q[$];
    oflit_t        exp_q[$];
    bit            model_body;
    logic [MW-1:0] cur_meta;
    int unsigned   exp_pkt, exp_drop, exp_err;
    bit            pkt_fire, meta_fire, stall_prev, fwd_prev;
    logic [127:0]  snap;
    int            gap, ready_mode, meta_hold, stalls, cyc;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic push_flit(input logic sop, input logic eop);
        flit_t f;
        f.sop   = sop;
        f.eop   = eop;
        f.data  = {$urandom, $urandom};
        f.empty = EW'($urandom_range(7));
        src_q.push_back(f);
    endtask

    task automatic push_meta(input logic [MW-1:0] m);
        meta_q.push_back(m);
        model_meta_q.push_back(m);
    endtask

    // Reference: IDLE drops non-sop, a sop starts a packet and takes the next meta,
    // sop inside a packet is forwarded as a body flit and counted, eop ends the packet.
    task automatic model_accept(input flit_t f, output bit fwd);
        oflit_t o;
        fwd = 1'b1;
        o.eop = f.eop; o.data = f.data; o.empty = f.empty;
        if (!model_body) begin
            if (!f.sop) begin
                exp_drop++;
                fwd = 1'b0;
            end else begin
                cur_meta   = model_meta_q.pop_front();
                model_body = !f.eop;
            end
            o.sop = 1'b1;
        end else begin
            if (f.sop) exp_err++;
            if (f.eop) model_body = 1'b0;
            o.sop = 1'b0;
        end
        o.meta = cur_meta;
        if (fwd) begin
            exp_q.push_back(o);
            if (o.eop) exp_pkt++;
        end
    endtask

    task automatic monitor();
        oflit_t       e;
        flit_t        f;
        bit           start, fwd;
        logic [127:0] now_v;
        now_v = 128'({bus.out_sop, bus.out_eop, bus.out_data, bus.out_empty, bus.out_meta});
        if (stall_prev) begin
            check("hold_valid", 128'(bus.out_valid), 128'(1));
            check("hold_fields", now_v, snap);
        end
        if (ready_mode == 0) check("latency", 128'(bus.out_valid), 128'(fwd_prev));
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) check("unexpected_out", 128'(1), 128'(0));
            else begin
                e = exp_q.pop_front();
                check("out_flit", now_v, 128'({e.sop, e.eop, e.data, e.empty, e.meta}));
            end
        end
        stall_prev = bus.out_valid && !bus.out_ready;
        snap       = now_v;
        pkt_fire   = bus.in_pkt_valid && bus.in_pkt_ready;
        meta_fire  = bus.in_meta_valid && bus.in_meta_ready;
        if (bus.in_pkt_valid && !bus.in_pkt_ready) stalls++;
        start = pkt_fire && bus.in_pkt_sop && !model_body;
        if (pkt_fire || meta_fire) check("meta_pop", 128'(meta_fire), 128'(start));
        fwd = 1'b0;
        if (pkt_fire) begin
            f.sop = bus.in_pkt_sop; f.eop = bus.in_pkt_eop;
            f.data = bus.in_pkt_data; f.empty = bus.in_pkt_empty;
            model_accept(f, fwd);
        end
        fwd_prev = fwd;
    endtask

    task automatic drive();
        if (pkt_fire) void'(src_q.pop_front());
        if (meta_fire) void'(meta_q.pop_front());
        if (!bus.in_pkt_valid || pkt_fire) begin
            if (src_q.size() > 0 && $urandom_range(99) >= gap) begin
                bus.in_pkt_valid = 1'b1;
                bus.in_pkt_sop   = src_q[0].sop;
                bus.in_pkt_eop   = src_q[0].eop;
                bus.in_pkt_data  = src_q[0].data;
                bus.in_pkt_empty = src_q[0].empty;
            end else begin
                bus.in_pkt_valid = 1'b0;
                bus.in_pkt_sop   = 1'($urandom_range(1));
                bus.in_pkt_data  = {$urandom, $urandom};
            end
        end
        if (!bus.in_meta_valid || meta_fire) begin
            if (meta_hold > 0) begin
                bus.in_meta_valid = 1'b0;
                meta_hold--;
            end else if (meta_q.size() > 0 && $urandom_range(99) >= gap) begin
                bus.in_meta_valid = 1'b1;
                bus.in_meta_data  = meta_q[0];
            end else begin
                bus.in_meta_valid = 1'b0;
                bus.in_meta_data  = $urandom;
            end
        end
        case (ready_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = 1'($urandom_range(1));
            default: bus.out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        endcase
        pkt_fire  = 1'b0;
        meta_fire = 1'b0;
    endtask

    task automatic reset_dut();
        Rst = 1'b1;
        bus.in_pkt_valid  = 1'b1;
        bus.in_pkt_sop    = 1'b1;
        bus.in_meta_valid = 1'b1;
        bus.out_ready     = 1'b1;
        @(posedge Clk); #1;
        check("rst_pkt_ready", 128'(bus.in_pkt_ready), 128'(0));
        check("rst_meta_ready", 128'(bus.in_meta_ready), 128'(0));
        @(posedge Clk); #1;
        Rst = 1'b0;
        bus.in_pkt_valid  = 1'b0;
        bus.in_meta_valid = 1'b0;
        check("rst_out", 128'({bus.out_valid, bus.out_sop, bus.out_eop, bus.out_data,
                               bus.out_empty, bus.out_meta}), 128'(0));
        check("rst_stats", 128'({stats_pkt, stats_drop, stats_err}), 128'(0));
        src_q.delete(); meta_q.delete(); model_meta_q.delete(); exp_q.delete();
        model_body = 1'b0; cur_meta = '0;
        exp_pkt = 0; exp_drop = 0; exp_err = 0;
        pkt_fire = 1'b0; meta_fire = 1'b0; stall_prev = 1'b0; fwd_prev = 1'b0;
    endtask

    task automatic run(input int mode, input int gap_pct, input int mdelay);
        bit done;
        ready_mode = mode; gap = gap_pct; meta_hold = mdelay;
        stalls = 0; cyc = 0; done = 1'b0;
        drive();
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge Clk);
            monitor();
            cyc++;
            @(posedge Clk); #1;
            drive();
            done = src_q.size() == 0 && meta_q.size() == 0 && exp_q.size() == 0 && !bus.out_valid;
        end
        if (!done) check("timeout", 128'(0), 128'(1));
        bus.in_pkt_valid  = 1'b0;
        bus.in_meta_valid = 1'b0;
        check("stats_pkt", 128'(stats_pkt), 128'(exp_pkt));
        check("stats_drop", 128'(stats_drop), 128'(exp_drop));
        check("stats_err", 128'(stats_err), 128'(exp_err));
    endtask

    task automatic gen_random(input int npk);
        int len;
        for (int p = 0; p < npk; p++) begin
            if ($urandom_range(99) < 15) push_flit(1'b0, 1'($urandom_range(1)));
            len = $urandom_range(4, 1);
            push_meta($urandom);
            for (int k = 0; k < len; k++)
                push_flit((k == 0) || ($urandom_range(99) < 15), k == len - 1);
        end
    endtask

    initial begin
        Rst = 1'b1;
        bus.in_pkt_valid = 1'b0; bus.in_pkt_sop = 1'b0; bus.in_pkt_eop = 1'b0;
        bus.in_pkt_data = '0; bus.in_pkt_empty = '0;
        bus.in_meta_valid = 1'b0; bus.in_meta_data = '0; bus.out_ready = 1'b1;

        // 3-flit packet with meta 0xA5
        reset_dut();
        push_meta(32'hA5);
        push_flit(1'b1, 1'b0); push_flit(1'b0, 1'b0); push_flit(1'b0, 1'b1);
        run(0, 0, 0);
        check("t1_stalls", 128'(stalls), 128'(0));

        // sop waits five cycles for its meta
        reset_dut();
        push_meta(32'h11);
        push_flit(1'b1, 1'b0); push_flit(1'b0, 1'b1);
        run(0, 0, 5);
        check("t2_stalls", 128'(stalls), 128'(5));

        // two leading non-sop flits are dropped
        reset_dut();
        push_flit(1'b0, 1'b0); push_flit(1'b0, 1'b1);
        run(0, 0, 0);

        // 4-flit packet under a 1,0,0,1 ready pattern
        reset_dut();
        push_meta($urandom);
        for (int k = 0; k < 4; k++) push_flit(k == 0, k == 3);
        run(2, 0, 0);

        // back-to-back single-flit packets
        reset_dut();
        for (int k = 1; k <= 3; k++) begin
            push_meta(MW'(k));
            push_flit(1'b1, 1'b1);
        end
        run(0, 0, 0);
        check("t5_stalls", 128'(stalls), 128'(0));

        // stray sop, then reset mid-packet; a following body flit must be dropped from IDLE
        reset_dut();
        push_meta(32'h77);
        push_flit(1'b1, 1'b0); push_flit(1'b1, 1'b0);
        run(0, 0, 0);
        reset_dut();
        push_flit(1'b0, 1'b1);
        run(0, 0, 0);

        // randomized traffic
        reset_dut();
        gen_random(40);
        run(1, 30, 0);
        reset_dut();
        gen_random(40);
        run(0, 20, 3);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
